// File: rtl/restoring_divider_ctrl.sv
// Purpose : unsigned 6-bit restoring divider sequencing one shared ripple-borrow subtractor.
// Latency : start edge E0, six trial subtractions on E1..E6, done strobe the cycle after E6;
//           a zero divisor short-circuits to done the cycle after E0.
// Backpres: none; start is only sampled in IDLE and is dropped (not queued) while busy or done.
//
// Ports:
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   start               request pulse, sampled only in IDLE
//   dividend, divisor   operands, captured on the start edge
//   busy                high while iterating
//   done                one-cycle result strobe
//   quotient, remainder result, held until the next result
//   div_zero            last request had a zero divisor, held with the result

// Ripple-borrow subtractor: diff = a - b - borrowIn, borrowOut set when a < b + borrowIn.
module arithmeticUnit (
    input  logic [5:0] a,
    input  logic [5:0] b,
    input  logic       borrowIn,
    output logic [5:0] diff,
    output logic       borrowOut
);
    logic bw;

    always_comb begin
        diff = '0;
        bw   = borrowIn;
        for (int i = 0; i < 6; i++) begin
            diff[i] = a[i] ^ b[i] ^ bw;
            bw      = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & bw);
        end
        borrowOut = bw;
    end
endmodule

module restoring_divider_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [5:0] dividend,
    input  logic [5:0] divisor,
    output logic       busy,
    output logic       done,
    output logic [5:0] quotient,
    output logic [5:0] remainder,
    output logic       div_zero
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state;
    state_t     stateNext;

    logic [5:0] q_sh;
    logic [5:0] r;
    logic [5:0] d;
    logic [2:0] cnt;

    logic [5:0] trial;
    logic [5:0] diff;
    logic       borrowOut;
    logic       qBit;
    logic [5:0] rNext;
    logic [5:0] qShNext;

    // Next dividend bit joins the partial remainder; r[5] is always 0 here,
    // so dropping it loses nothing.
    assign trial = {r[4:0], q_sh[5]};

    arithmeticUnit u_sub (
        .a        (trial),
        .b        (d),
        .borrowIn (1'b0),
        .diff     (diff),
        .borrowOut(borrowOut)
    );

    // No borrow means trial >= d: keep the difference and emit a 1.
    // A borrow means the trial failed: restore by keeping trial and emit a 0.
    assign qBit    = ~borrowOut;
    assign rNext   = borrowOut ? trial : diff;
    assign qShNext = {q_sh[4:0], qBit};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    stateNext = (divisor == 6'd0) ? DONE : ITER;
                end
            end
            ITER: begin
                busy = 1'b1;
                if (cnt == 3'd0) begin
                    stateNext = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_sh      <= '0;
            r         <= '0;
            d         <= '0;
            cnt       <= '0;
            quotient  <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (divisor != 6'd0) begin
                            q_sh <= dividend;
                            d    <= divisor;
                            r    <= '0;
                            cnt  <= 3'd5;
                        end else begin
                            quotient  <= 6'h3F;
                            remainder <= dividend;
                            div_zero  <= 1'b1;
                        end
                    end
                end
                ITER: begin
                    r    <= rNext;
                    q_sh <= qShNext;
                    cnt  <= cnt - 3'd1;
                    if (cnt == 3'd0) begin
                        quotient  <= qShNext;
                        remainder <= rNext;
                        div_zero  <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // The partial remainder never outgrows the consumed dividend prefix.
    remainderFits: assert property (@(posedge clk) disable iff (!rst_n)
        (state == ITER) |-> (r[5] == 1'b0));

endmodule

// File: tb/tb_restoring_divider_ctrl.sv
module tb_restoring_divider_ctrl;
    logic       clk;
    logic       rst_n;
    logic       start;
    logic [5:0] dividend;
    logic [5:0] divisor;
    logic       busy;
    logic       done;
    logic [5:0] quotient;
    logic [5:0] remainder;
    logic       div_zero;

    int total;
    int bad;

    restoring_divider_ctrl dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .dividend (dividend),
        .divisor  (divisor),
        .busy     (busy),
        .done     (done),
        .quotient (quotient),
        .remainder(remainder),
        .div_zero (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
    task automatic doDiv(input logic [5:0] a, input logic [5:0] b,
                         input logic [5:0] eq, input logic [5:0] er, input logic ez);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(negedge clk);
        start    = 1'b0;
        dividend = 6'($urandom);
        divisor  = 6'($urandom);
        if (b != 6'd0) begin
            for (int i = 0; i < 6; i++) begin
                check("busy_iter", 32'(busy), 32'd1);
                check("done_early", 32'(done), 32'd0);
                @(negedge clk);
            end
        end
        check("done_strobe", 32'(done), 32'd1);
        check("busy_in_done", 32'(busy), 32'd0);
        check("quotient", 32'(quotient), 32'(eq));
        check("remainder", 32'(remainder), 32'(er));
        check("div_zero", 32'(div_zero), 32'(ez));
        @(negedge clk);
        check("done_width", 32'(done), 32'd0);
        check("busy_after", 32'(busy), 32'd0);
    endtask

    initial begin
        int         doneCnt;
        logic [5:0] capQ;
        logic [5:0] capR;
        logic [5:0] eq;
        logic [5:0] er;

        total    = 0;
        bad      = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = 6'd0;
        divisor  = 6'd0;

        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_quotient", 32'(quotient), 32'd0);
        check("rst_remainder", 32'(remainder), 32'd0);
        check("rst_div_zero", 32'(div_zero), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed vectors, hand-computed.
        doDiv(6'd45, 6'd7, 6'd6, 6'd3, 1'b0);
        doDiv(6'd63, 6'd1, 6'd63, 6'd0, 1'b0);
        doDiv(6'd5, 6'd9, 6'd0, 6'd5, 1'b0);
        doDiv(6'd0, 6'd13, 6'd0, 6'd0, 1'b0);
        doDiv(6'd63, 6'd63, 6'd1, 6'd0, 1'b0);
        doDiv(6'd20, 6'd0, 6'd63, 6'd20, 1'b1);
        doDiv(6'd20, 6'd4, 6'd5, 6'd0, 1'b0);
        doDiv(6'd62, 6'd2, 6'd31, 6'd0, 1'b0);
        doDiv(6'd32, 6'd33, 6'd0, 6'd32, 1'b0);

        // Re-pulsing start mid-iteration must be ignored.
        start    = 1'b1;
        dividend = 6'd45;
        divisor  = 6'd7;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start    = 1'b1;
        dividend = 6'd50;
        divisor  = 6'd3;
        @(negedge clk);
        start   = 1'b0;
        doneCnt = 0;
        capQ    = 6'd0;
        capR    = 6'd0;
        for (int i = 0; i < 8; i++) begin
            if (done) begin
                doneCnt++;
                capQ = quotient;
                capR = remainder;
            end
            @(negedge clk);
        end
        check("repulse_done_count", 32'(doneCnt), 32'd1);
        check("repulse_quotient", 32'(capQ), 32'd6);
        check("repulse_remainder", 32'(capR), 32'd3);
        check("repulse_idle", 32'(busy), 32'd0);

        // Reset during the third iteration cycle aborts with no done.
        start    = 1'b1;
        dividend = 6'd45;
        divisor  = 6'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        check("pre_reset_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_quotient", 32'(quotient), 32'd0);
        check("arst_remainder", 32'(remainder), 32'd0);
        check("arst_div_zero", 32'(div_zero), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("arst_no_done", 32'(done), 32'd0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("post_reset_no_done", 32'(done), 32'd0);
        end
        doDiv(6'd45, 6'd7, 6'd6, 6'd3, 1'b0);

        // Exhaustive operand sweep against integer division.
        for (int a = 0; a < 64; a++) begin
            for (int b = 0; b < 64; b++) begin
                if (b == 0) begin
                    eq = 6'h3F;
                    er = 6'(a);
                end else begin
                    eq = 6'(a / b);
                    er = 6'(a % b);
                end
                doDiv(6'(a), 6'(b), eq, er, (b == 0));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
